doc_led_7doan_quet: RTL and testbench
=====================================

# doc_led_7doan_quet

Scan-reader for a multiplexed, active-high 7-segment display bus: watches the digit-enable lines and the `{dp,g..a}` segment bus, samples each digit once its pattern has settled, and converts each segment pattern back to a 4-bit hex value. A full frame is published atomically with a one-cycle strobe once every digit has been seen. It is the receive end of the hex-to-7-segment decode path and is used for display self-check and loop-back testing.

## Interface
- `N_DIGIT`, 8 — number of multiplexed digits; width of `ena_led`.
- `STABLE_CNT`, 4 — consecutive cycles an input must stay unchanged before it is sampled; legal range 1..255.

- `ckht`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ena_led`  in  N_DIGIT  digit enables, active-high. Bit i selects digit i. Valid patterns are one-hot or all-zero (blanking gap).
- `sseg`  in  8  segment bus, active-high. Bit 7 is dp; bits 6..0 are g..a.
- `so_hex`  out  4*N_DIGIT  decoded digits. Digit i is in bits `[4i+3:4i]`.
- `dp_out`  out  N_DIGIT  captured dp bit per digit.
- `digit_ok`  out  N_DIGIT  1 = digit i held a legal hex pattern in the last frame.
- `frame_valid`  out  1  one-cycle pulse when the output registers update.
- `onehot_err`  out  1  one-cycle pulse when a stable `ena_led` has two or more bits set.

## Operation
- **Input register:** `{ena_led,sseg}` is registered every cycle into `in_r`. The inputs are synchronous to `ckht`.
- **Stability counter `cnt`:**
  - Cleared when the current input differs from `in_r`.
  - Otherwise incremented, saturating at `STABLE_CNT`.
- **States:**
  - CHO (wait): entered on any input change.
  - LAY_MAU (sample): entered for exactly one cycle when `cnt` reaches `STABLE_CNT`.
  - DA_LAY (taken): holds until the next input change, so each settled pattern is acted on at most once.
- **LAY_MAU action by `ena_led`:**
  - One-hot, bit i: write the shadow nibble, dp and ok flag for digit i, and set `mask[i]`.
  - All zero: no action.
  - Two or more bits set: pulse `onehot_err`; no shadow write.
- **Reverse decode of `sseg[6:0]`:**
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F.
  - Any other pattern, including 00 (blank): nibble 0, ok 0.
  - dp is captured unconditionally.
- **Frame assembly:**
  - A digit sampled again before the frame completes overwrites its shadow entry; the latest value wins.
  - When `mask` becomes all ones, the next edge copies the shadow into `so_hex`, `dp_out` and `digit_ok`, pulses `frame_valid`, and clears `mask`.
  - The outputs hold between frames.
- **Reset:**
  - Every output resets to 0: `so_hex`, `dp_out`, `digit_ok`, `frame_valid`, `onehot_err`.
  - Internal state also clears: `mask`, `cnt`, `in_r`, the shadow, and the state (CHO).
  - Reset mid-frame discards the partial frame.

## Timing
- **Sample edge:** an input presented before edge k and held is sampled at edge k+STABLE_CNT (shadow write, `mask` bit set).
- **Minimum hold:** an input must be held ≥ STABLE_CNT+1 cycles to be sampled. Shorter holds are discarded with no side effects.
- **Frame latency:** `frame_valid` and the updated outputs appear one edge after the sample that completes `mask`.
- **Overlapping events:** if a new frame's first sample coincides with the publish edge, the sample lands in the cleared `mask` and is kept.
- **Error pulse:** `onehot_err` fires in the LAY_MAU cycle; it fires once per stable illegal pattern, not every cycle.
- **Saturation:** `cnt` never wraps.
- **STABLE_CNT = 1:** a two-cycle hold is sufficient.

## Test plan
1. **Normal frame.** N_DIGIT=4, STABLE_CNT=4. Digits 0..3 each held 8 cycles with `sseg` 0x3F, 0x06, 0x5B, 0xCF, separated by 2-cycle all-zero gaps. Required: `so_hex`=0x3210, `dp_out`=4'b1000, `digit_ok`=4'b1111, exactly one `frame_valid` pulse, 1 cycle after the digit-3 sample.
2. **Glitch rejection.** Digit 1 held with 0x06 for 4 cycles, then changed. Required: no sample, `mask[1]` stays 0, no `frame_valid`. Then hold 0x06 for 5 cycles. Required: exactly one sample.
3. **Illegal pattern.** Digit 2 shows 0x49 in an otherwise valid frame. Required: `so_hex[11:8]`=0, `digit_ok[2]`=0, frame still published.
4. **Multi-hot enable.** `ena_led`=4'b0011 held 10 cycles. Required: one `onehot_err` pulse; `mask` unchanged.
5. **Decode sweep.** 16 frames, digit 0 cycling through all 16 legal codes. Required: `so_hex[3:0]` = 0..F in order, `digit_ok[0]`=1 throughout.
6. **Reset mid-frame.** Assert `rst` after digits 0..1 are sampled, then scan only digits 2..3. Required: outputs 0 and no `frame_valid` until digits 0..3 are all re-sampled.

Source files
------------

// File: rtl/doc_led_7doan_quet_if.sv
// Bus between a multiplexed 7-segment display driver and the scan-reader.
// The display side drives the enables/segments; the reader returns decoded frames.
interface doc_led_7doan_quet_if #(
  parameter int N_DIGIT = 8
);
  logic [N_DIGIT-1:0]   ena_led;
  logic [7:0]           sseg;
  logic [4*N_DIGIT-1:0] so_hex;
  logic [N_DIGIT-1:0]   dp_out;
  logic [N_DIGIT-1:0]   digit_ok;
  logic                 frame_valid;
  logic                 onehot_err;

  modport master (
    output ena_led,
    output sseg,
    input  so_hex,
    input  dp_out,
    input  digit_ok,
    input  frame_valid,
    input  onehot_err
  );

  modport slave (
    input  ena_led,
    input  sseg,
    output so_hex,
    output dp_out,
    output digit_ok,
    output frame_valid,
    output onehot_err
  );
endinterface

// File: rtl/doc_led_7doan_quet.sv
// Scan-reader for a multiplexed active-high 7-segment bus: samples each settled
// digit, reverse-decodes it to hex and publishes whole frames with a strobe.
module doc_led_7doan_quet #(
  parameter int N_DIGIT    = 8,
  parameter int STABLE_CNT = 4
) (
  input logic                 ckht,
  input logic                 rst,
  doc_led_7doan_quet_if.slave bus
);
  localparam int          IN_W     = N_DIGIT + 8;
  localparam logic [7:0]  CNT_MAX  = 8'(STABLE_CNT);

  typedef enum logic [1:0] {
    CHO     = 2'd0,
    LAY_MAU = 2'd1,
    DA_LAY  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [IN_W-1:0]      in_cur;
  logic [IN_W-1:0]      in_r_q, in_r_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 changed;

  logic [N_DIGIT-1:0]   ena_s;
  logic [7:0]           sseg_s;
  logic                 sample;
  logic                 ena_zero;
  logic                 ena_onehot;
  logic [3:0]           dec_nib;
  logic                 dec_ok;

  logic [N_DIGIT-1:0]   mask_q, mask_d;
  logic [4*N_DIGIT-1:0] sh_hex_q, sh_hex_d;
  logic [N_DIGIT-1:0]   sh_dp_q, sh_dp_d;
  logic [N_DIGIT-1:0]   sh_ok_q, sh_ok_d;
  logic [4*N_DIGIT-1:0] so_hex_q, so_hex_d;
  logic [N_DIGIT-1:0]   dp_out_q, dp_out_d;
  logic [N_DIGIT-1:0]   digit_ok_q, digit_ok_d;
  logic                 frame_valid_q, frame_valid_d;
  logic                 onehot_err_q, onehot_err_d;

  function automatic logic [4:0] seg_to_hex(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h3F:   r = {1'b1, 4'h0};
      7'h06:   r = {1'b1, 4'h1};
      7'h5B:   r = {1'b1, 4'h2};
      7'h4F:   r = {1'b1, 4'h3};
      7'h66:   r = {1'b1, 4'h4};
      7'h6D:   r = {1'b1, 4'h5};
      7'h7D:   r = {1'b1, 4'h6};
      7'h07:   r = {1'b1, 4'h7};
      7'h7F:   r = {1'b1, 4'h8};
      7'h6F:   r = {1'b1, 4'h9};
      7'h77:   r = {1'b1, 4'hA};
      7'h7C:   r = {1'b1, 4'hB};
      7'h39:   r = {1'b1, 4'hC};
      7'h5E:   r = {1'b1, 4'hD};
      7'h79:   r = {1'b1, 4'hE};
      7'h71:   r = {1'b1, 4'hF};
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  assign in_cur = {bus.ena_led, bus.sseg};
  assign ena_s  = in_r_q[IN_W-1:8];
  assign sseg_s = in_r_q[7:0];

  // Stability counter: restarts on any input change, saturates at CNT_MAX.
  always_comb begin
    in_r_d  = in_cur;
    changed = (in_cur != in_r_q);
    if (changed) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (changed) begin
      state_d = CHO;
    end else begin
      case (state_q)
        CHO:     if (cnt_d == CNT_MAX) state_d = LAY_MAU;
        LAY_MAU: state_d = DA_LAY;
        default: state_d = DA_LAY;
      endcase
    end
  end

  // The sample happens on the edge that enters LAY_MAU, so the one-cycle
  // LAY_MAU state is when the sample's registered effects are visible.
  always_comb begin
    sample     = (state_q == CHO) && (state_d == LAY_MAU);
    ena_zero   = (ena_s == '0);
    ena_onehot = !ena_zero && ((ena_s & (ena_s - N_DIGIT'(1))) == '0);
    {dec_ok, dec_nib} = seg_to_hex(sseg_s[6:0]);
  end

  always_comb begin
    mask_d        = mask_q;
    sh_hex_d      = sh_hex_q;
    sh_dp_d       = sh_dp_q;
    sh_ok_d       = sh_ok_q;
    so_hex_d      = so_hex_q;
    dp_out_d      = dp_out_q;
    digit_ok_d    = digit_ok_q;
    frame_valid_d = 1'b0;
    onehot_err_d  = 1'b0;

    // Publish reads the old shadow; a coincident sample lands in the fresh mask.
    if (&mask_q) begin
      so_hex_d      = sh_hex_q;
      dp_out_d      = sh_dp_q;
      digit_ok_d    = sh_ok_q;
      frame_valid_d = 1'b1;
      mask_d        = '0;
    end

    if (sample) begin
      if (ena_onehot) begin
        for (int unsigned i = 0; i < N_DIGIT; i++) begin
          if (ena_s[i]) begin
            sh_hex_d[4*i +: 4] = dec_nib;
            sh_dp_d[i]         = sseg_s[7];
            sh_ok_d[i]         = dec_ok;
            mask_d[i]          = 1'b1;
          end
        end
      end else if (!ena_zero) begin
        onehot_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge ckht or posedge rst) begin
    if (rst) begin
      state_q       <= CHO;
      in_r_q        <= '0;
      cnt_q         <= '0;
      mask_q        <= '0;
      sh_hex_q      <= '0;
      sh_dp_q       <= '0;
      sh_ok_q       <= '0;
      so_hex_q      <= '0;
      dp_out_q      <= '0;
      digit_ok_q    <= '0;
      frame_valid_q <= 1'b0;
      onehot_err_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_r_q        <= in_r_d;
      cnt_q         <= cnt_d;
      mask_q        <= mask_d;
      sh_hex_q      <= sh_hex_d;
      sh_dp_q       <= sh_dp_d;
      sh_ok_q       <= sh_ok_d;
      so_hex_q      <= so_hex_d;
      dp_out_q      <= dp_out_d;
      digit_ok_q    <= digit_ok_d;
      frame_valid_q <= frame_valid_d;
      onehot_err_q  <= onehot_err_d;
    end
  end

  assign bus.so_hex      = so_hex_q;
  assign bus.dp_out      = dp_out_q;
  assign bus.digit_ok    = digit_ok_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.onehot_err  = onehot_err_q;

endmodule

// File: tb/tb_doc_led_7doan_quet.sv
// Bench for doc_led_7doan_quet: a run-length/lookup-table model predicts every
// output each cycle; directed scenarios add literal expectations on top.
module tb_doc_led_7doan_quet;
  localparam int ND = 4;
  localparam int SC = 4;

  logic ckht = 1'b0;
  logic rst  = 1'b1;

  doc_led_7doan_quet_if #(.N_DIGIT(ND)) ifc ();

  doc_led_7doan_quet #(.N_DIGIT(ND), .STABLE_CNT(SC)) dut (
    .ckht (ckht),
    .rst  (rst),
    .bus  (ifc)
  );

  always #5 ckht = ~ckht;

  int checks = 0;
  int errors = 0;
  int fv_cnt = 0;
  int err_cnt = 0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [4:0] dec(input logic [6:0] s);
    for (int v = 0; v < 16; v++) begin
      if (seg_tab[v] == s) return {1'b1, 4'(v)};
    end
    return 5'd0;
  endfunction

  // Inputs and reset as seen by each rising edge
  logic [11:0] cap_in;
  logic        cap_rst;
  always @(posedge ckht) begin
    cap_in  <= {ifc.ena_led, ifc.sseg};
    cap_rst <= rst;
  end

  // Model state: run length of the current input, shadow frame, published frame
  logic [11:0] prev;
  int          hold;
  logic [15:0] sh_hex, exp_hex;
  logic [3:0]  sh_dp, sh_ok, mask, exp_dp, exp_ok;
  logic        exp_fv, exp_err;
  logic [3:0]  m_e;
  logic [4:0]  m_d;

  initial begin
    forever begin
      @(negedge ckht);
      if (cap_rst !== 1'b0) begin
        prev = '0; hold = 1;
        sh_hex = '0; sh_dp = '0; sh_ok = '0; mask = '0;
        exp_hex = '0; exp_dp = '0; exp_ok = '0; exp_fv = 1'b0; exp_err = 1'b0;
      end else begin
        exp_fv  = (mask == 4'hF);
        exp_err = 1'b0;
        if (exp_fv) begin
          exp_hex = sh_hex; exp_dp = sh_dp; exp_ok = sh_ok; mask = '0;
        end
        if (cap_in == prev) begin
          if (hold < SC + 2) hold++;
        end else begin
          hold = 1;
        end
        prev = cap_in;
        if (hold == SC + 1) begin
          m_e = cap_in[11:8];
          if ($countones(m_e) == 1) begin
            for (int i = 0; i < ND; i++) begin
              if (m_e[i]) begin
                m_d = dec(cap_in[6:0]);
                sh_hex[4*i +: 4] = m_d[3:0];
                sh_ok[i] = m_d[4];
                sh_dp[i] = cap_in[7];
                mask[i]  = 1'b1;
              end
            end
          end else if ($countones(m_e) > 1) begin
            exp_err = 1'b1;
          end
        end
      end
      check("so_hex",      32'(ifc.so_hex),      32'(exp_hex));
      check("dp_out",      32'(ifc.dp_out),      32'(exp_dp));
      check("digit_ok",    32'(ifc.digit_ok),    32'(exp_ok));
      check("frame_valid", 32'(ifc.frame_valid), 32'(exp_fv));
      check("onehot_err",  32'(ifc.onehot_err),  32'(exp_err));
      if (ifc.frame_valid === 1'b1) fv_cnt++;
      if (ifc.onehot_err === 1'b1) err_cnt++;
    end
  end

  task automatic show(input logic [3:0] e, input logic [7:0] s, input int n);
    ifc.ena_led = e;
    ifc.sseg    = s;
    repeat (n) @(negedge ckht);
  endtask

  task automatic digit(input int d, input logic [7:0] s, input int n, input int gap);
    show(4'(1 << d), s, n);
    if (gap > 0) show(4'h0, 8'h00, gap);
  endtask

  task automatic do_reset();
    ifc.ena_led = '0;
    ifc.sseg    = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge ckht);
    #1 rst = 1'b0;
  endtask

  int          fv0, e0;
  logic [7:0]  s8;
  logic [3:0]  e4;
  int          r;

  initial begin
    ifc.ena_led = '0;
    ifc.sseg    = '0;
    repeat (2) @(negedge ckht);
    #1;
    check("reset so_hex", 32'(ifc.so_hex), 32'h0);
    check("reset dp_out", 32'(ifc.dp_out), 32'h0);
    check("reset digit_ok", 32'(ifc.digit_ok), 32'h0);
    check("reset frame_valid", 32'(ifc.frame_valid), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge ckht);

    // Normal frame
    fv0 = fv_cnt;
    digit(0, 8'h3F, 8, 2);
    digit(1, 8'h06, 8, 2);
    digit(2, 8'h5B, 8, 2);
    show(4'h8, 8'hCF, 5);
    #1 check("t1 no early frame_valid", 32'(ifc.frame_valid), 32'h0);
    show(4'h8, 8'hCF, 1);
    #1 check("t1 frame_valid latency", 32'(ifc.frame_valid), 32'h1);
    check("t1 so_hex", 32'(ifc.so_hex), 32'h3210);
    check("t1 dp_out", 32'(ifc.dp_out), 32'h8);
    check("t1 digit_ok", 32'(ifc.digit_ok), 32'hF);
    show(4'h8, 8'hCF, 2);
    show(4'h0, 8'h00, 2);
    check("t1 one pulse", 32'(fv_cnt - fv0), 32'd1);

    // Glitch rejection: 4-cycle holds are ignored, 5-cycle hold samples once
    fv0 = fv_cnt;
    digit(1, 8'h06, 4, 2);
    digit(1, 8'h5B, 4, 2);
    #1 check("t2 no frame", 32'(fv_cnt - fv0), 32'd0);
    digit(1, 8'h06, 5, 2);

    // Illegal pattern on digit 2 (digit 1 comes from the glitch test)
    digit(0, 8'h66, 6, 2);
    digit(2, 8'h49, 6, 2);
    digit(3, 8'h7D, 6, 2);
    #1 check("t3 one frame", 32'(fv_cnt - fv0), 32'd1);
    check("t3 so_hex", 32'(ifc.so_hex), 32'h6014);
    check("t3 digit_ok", 32'(ifc.digit_ok), 32'hB);
    check("t3 dp_out", 32'(ifc.dp_out), 32'h0);

    // Multi-hot enable: one error pulse, no mask bits
    fv0 = fv_cnt;
    e0  = err_cnt;
    show(4'h3, 8'h3F, 10);
    show(4'h0, 8'h00, 2);
    #1 check("t4 one onehot_err", 32'(err_cnt - e0), 32'd1);
    digit(2, 8'h06, 6, 2);
    digit(3, 8'h06, 6, 2);
    #1 check("t4 mask untouched", 32'(fv_cnt - fv0), 32'd0);
    digit(0, 8'h7F, 6, 2);
    digit(1, 8'h6F, 6, 2);
    #1 check("t4 frame", 32'(fv_cnt - fv0), 32'd1);
    check("t4 so_hex", 32'(ifc.so_hex), 32'h1198);

    // Decode sweep on digit 0, random content and timing elsewhere
    for (int v = 0; v < 16; v++) begin
      fv0 = fv_cnt;
      s8 = {1'($urandom), seg_tab[v]};
      digit(0, s8, $urandom_range(5, 9), $urandom_range(0, 2));
      for (int d = 1; d < ND; d++) begin
        digit(d, 8'($urandom), $urandom_range(5, 9), $urandom_range(0, 2));
      end
      show(4'h0, 8'h00, 2);
      #1 check("t5 frame", 32'(fv_cnt - fv0), 32'd1);
      check("t5 so_hex[3:0]", 32'(ifc.so_hex[3:0]), 32'(v));
      check("t5 digit_ok[0]", 32'(ifc.digit_ok[0]), 32'h1);
    end

    // Reset mid-frame discards digits 0..1
    digit(0, 8'h6D, 6, 2);
    digit(1, 8'h07, 6, 2);
    do_reset();
    @(negedge ckht);
    #1 check("t6 so_hex cleared", 32'(ifc.so_hex), 32'h0);
    check("t6 dp_out cleared", 32'(ifc.dp_out), 32'h0);
    check("t6 digit_ok cleared", 32'(ifc.digit_ok), 32'h0);
    fv0 = fv_cnt;
    digit(2, 8'h79, 6, 2);
    digit(3, 8'hF1, 6, 2);
    digit(0, 8'h77, 6, 2);
    #1 check("t6 still no frame", 32'(fv_cnt - fv0), 32'd0);
    check("t6 so_hex held 0", 32'(ifc.so_hex), 32'h0);
    digit(1, 8'h7C, 6, 2);
    #1 check("t6 frame", 32'(fv_cnt - fv0), 32'd1);
    check("t6 so_hex", 32'(ifc.so_hex), 32'hFEBA);
    check("t6 dp_out", 32'(ifc.dp_out), 32'h8);

    // Random scan traffic, model-checked every cycle
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 9);
      if (r < 2)      e4 = 4'h0;
      else if (r < 9) e4 = 4'(1 << $urandom_range(0, 3));
      else            e4 = 4'($urandom);
      if ($urandom_range(0, 1) == 1) s8 = {1'($urandom), seg_tab[$urandom_range(0, 15)]};
      else                           s8 = 8'($urandom);
      show(e4, s8, $urandom_range(1, 8));
    end
    show(4'h0, 8'h00, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
